// File: rtl/multimode_ff_bank.sv
// multimode_ff_bank: NCH channel registers with HOLD/D/JK/T writes,
// per-write change reporting and a sequenced bank-clear sweep.
module multimode_ff_bank #(
  parameter int               WIDTH     = 32,
  parameter int               NCH       = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$clog2(NCH)-1:0]  in_ch,
  input  logic [1:0]              in_mode,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  input  logic                    clr_req,
  output logic                    clr_done,
  output logic [NCH*WIDTH-1:0]    q,
  output logic                    chg_valid,
  output logic [$clog2(NCH)-1:0]  chg_ch,
  output logic [WIDTH-1:0]        chg_mask,
  output logic                    err
);

  localparam int CW = $clog2(NCH);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    ptr;
  logic [CW-1:0]    ptr_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] regs [NCH];
  logic             accept;
  logic             in_range;
  logic [WIDTH-1:0] old_v;
  logic [WIDTH-1:0] new_v;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign in_range = ({1'b0, in_ch} < (CW+1)'(NCH));

  // Old value of the addressed channel; zero when out of range.
  always_comb begin
    old_v = '0;
    for (int i = 0; i < NCH; i++) begin
      if (in_ch == CW'(i)) old_v = regs[i];
    end
  end

  always_comb begin
    new_v = old_v;
    unique case (in_mode)
      2'b00: new_v = old_v;
      2'b01: new_v = in_a;
      2'b10: new_v = (in_a & ~old_v) | (~in_b & old_v);
      2'b11: new_v = old_v ^ in_a;
      default: new_v = old_v;
    endcase
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    done_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (clr_req) begin
          state_nxt = S_CLEAR;
          ptr_nxt   = '0;
        end
      end
      S_CLEAR: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == CW'(NCH-1)) begin
          state_nxt = S_IDLE;
          ptr_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      clr_done <= done_nxt;
    end
  end

  // Sweep and writes never overlap: accept is only possible in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (state == S_CLEAR && ptr == CW'(i))
          regs[i] <= RESET_VAL;
        else if (accept && in_ch == CW'(i))
          regs[i] <= new_v;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chg_valid <= 1'b0;
      chg_ch    <= '0;
      chg_mask  <= '0;
      err       <= 1'b0;
    end else begin
      chg_valid <= accept & in_range;
      err       <= accept & ~in_range;
      if (accept && in_range) begin
        chg_ch   <= in_ch;
        chg_mask <= old_v ^ new_v;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_q
    assign q[g*WIDTH +: WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_multimode_ff_bank.sv
// tb_multimode_ff_bank: random and directed writes/sweeps checked
// against a per-bit reference model of the channel bank.
module tb_multimode_ff_bank;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_D    = 2'b01;
  localparam logic [1:0] M_JK   = 2'b10;
  localparam logic [1:0] M_T    = 2'b11;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_ch;
  logic [1:0]   in_mode;
  logic [31:0]  in_a;
  logic [31:0]  in_b;
  logic         clr_req;
  logic         clr_done;
  logic [127:0] q;
  logic         chg_valid;
  logic [1:0]   chg_ch;
  logic [31:0]  chg_mask;
  logic         err;

  logic         t_valid;
  logic         t_ready;
  logic [1:0]   t_ch;
  logic [1:0]   t_mode;
  logic [7:0]   t_a;
  logic [7:0]   t_b;
  logic         t_clr;
  logic         t_done;
  logic [23:0]  t_q;
  logic         t_chg_valid;
  logic [1:0]   t_chg_ch;
  logic [7:0]   t_chg_mask;
  logic         t_err;

  always #5 clk = ~clk;

  multimode_ff_bank #(.WIDTH(32), .NCH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b),
    .clr_req(clr_req), .clr_done(clr_done),
    .q(q), .chg_valid(chg_valid),
    .chg_ch(chg_ch), .chg_mask(chg_mask),
    .err(err)
  );

  multimode_ff_bank #(.WIDTH(8), .NCH(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(t_valid), .in_ready(t_ready),
    .in_ch(t_ch), .in_mode(t_mode),
    .in_a(t_a), .in_b(t_b),
    .clr_req(t_clr), .clr_done(t_done),
    .q(t_q), .chg_valid(t_chg_valid),
    .chg_ch(t_chg_ch), .chg_mask(t_chg_mask),
    .err(t_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m [4];
  int          sweep_left;
  logic        e_chg;
  logic [1:0]  e_ch;
  logic [31:0] e_mask;
  logic        e_done;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-bit truth table of each write mode.
  function automatic logic [31:0] ref_next(input logic [1:0] md,
                                           input logic [31:0] o,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 32; i++) begin
      case (md)
        M_D: r[i] = a[i];
        M_T: r[i] = a[i] ? ~o[i] : o[i];
        M_JK: begin
          if (a[i] && b[i])  r[i] = ~o[i];
          else if (a[i])     r[i] = 1'b1;
          else if (b[i])     r[i] = 1'b0;
        end
        default: r[i] = o[i];
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) m[c] = '0;
    sweep_left = 0;
    e_chg  = 1'b0;
    e_ch   = '0;
    e_mask = '0;
    e_done = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, 128'(in_ready), 128'(sweep_left == 0));
    chk({tag, ".chg_valid"}, 128'(chg_valid), 128'(e_chg));
    if (e_chg) begin
      chk({tag, ".chg_ch"}, 128'(chg_ch), 128'(e_ch));
      chk({tag, ".chg_mask"}, 128'(chg_mask), 128'(e_mask));
    end
    chk({tag, ".clr_done"}, 128'(clr_done), 128'(e_done));
    chk({tag, ".err"}, 128'(err), 128'(0));
    for (int c = 0; c < 4; c++)
      chk($sformatf("%s.q%0d", tag, c), 128'(q[c*32 +: 32]), 128'(m[c]));
  endtask

  // Called at a negedge: drive, predict, advance one cycle, check.
  task automatic step(input string tag, input logic v,
                      input logic [1:0] ch, input logic [1:0] md,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic clr);
    logic [31:0] nv;
    in_valid = v;
    in_ch    = ch;
    in_mode  = md;
    in_a     = a;
    in_b     = b;
    clr_req  = clr;
    e_chg  = 1'b0;
    e_done = 1'b0;
    if (sweep_left > 0) begin
      m[4 - sweep_left] = '0;
      sweep_left--;
      e_done = (sweep_left == 0);
    end else begin
      if (v) begin
        nv     = ref_next(md, m[ch], a, b);
        e_chg  = 1'b1;
        e_ch   = ch;
        e_mask = m[ch] ^ nv;
        m[ch]  = nv;
      end
      if (clr) sweep_left = 4;
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic t_write(input logic [1:0] ch, input logic [1:0] md,
                         input logic [7:0] a);
    t_valid = 1'b1;
    t_ch    = ch;
    t_mode  = md;
    t_a     = a;
    @(posedge clk);
    @(negedge clk);
    t_valid = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_ch    = '0;
    in_mode  = '0;
    in_a     = '0;
    in_b     = '0;
    clr_req  = 1'b0;
    t_valid  = 1'b0;
    t_ch     = '0;
    t_mode   = '0;
    t_a      = '0;
    t_b      = '0;
    t_clr    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_all("post_reset");

    step("d_ch2", 1, 2, M_D, 32'hA5A5_0F0F, 0, 0);
    chk("d_ch2.const", 128'(q[95:64]), 128'(32'hA5A5_0F0F));
    chk("d_ch2.mask", 128'(chg_mask), 128'(32'hA5A5_0F0F));
    step("jk_ch2", 1, 2, M_JK, 32'h0000_00F0, 32'h0000_000F, 0);
    chk("jk_ch2.const", 128'(q[95:64]), 128'(32'hA5A5_0FF0));
    step("t_ch2", 1, 2, M_T, 32'hFFFF_0000, 0, 0);
    chk("t_ch2.const", 128'(q[95:64]), 128'(32'h5A5A_0FF0));
    chk("t_ch2.mask", 128'(chg_mask), 128'(32'hFFFF_0000));
    step("hold_ch2", 1, 2, M_HOLD, 32'hFFFF_FFFF, 0, 0);

    step("b2b0", 1, 0, M_D, 32'd1, 0, 0);
    step("b2b1", 1, 1, M_D, 32'd2, 0, 0);
    step("b2b2", 1, 0, M_D, 32'd3, 0, 0);
    chk("b2b.ch0", 128'(q[31:0]), 128'(32'd3));
    chk("b2b.ch1", 128'(q[63:32]), 128'(32'd2));

    for (int c = 0; c < 4; c++)
      step("load", 1, 2'(c), M_D, $urandom | 32'h1000, 0, 0);
    step("clr_wr", 1, 3, M_T, 32'd1, 0, 1);
    step("sweep0", 1, 1, M_D, $urandom, 0, 0);
    step("sweep1", 1, 2, M_D, $urandom, 0, 1);
    step("sweep2", 0, 0, M_D, 0, 0, 1);
    step("sweep3", 1, 0, M_D, $urandom, 0, 0);
    chk("sweep.done", 128'(clr_done), 128'(1));
    chk("sweep.zero", 128'(q), 128'(0));
    step("after_sweep", 1, 1, M_D, 32'hCAFE_F00D, 0, 0);

    step("pre_rst", 0, 0, M_D, 0, 0, 1);
    step("rst_sw0", 0, 0, M_D, 0, 0, 0);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    @(negedge clk);
    check_all("mid_rst_hold");
    reset_n = 1'b1;
    @(negedge clk);
    check_all("rst_release");

    for (int n = 0; n < 400; n++) begin
      step($sformatf("rnd%0d", n),
           ($urandom_range(3) != 0),
           2'($urandom_range(3)),
           2'($urandom_range(3)),
           $urandom, $urandom,
           ($urandom_range(15) == 0));
    end

    t_write(2'd3, M_D, 8'h5A);
    chk("n3.err_oob", 128'(t_err), 128'(1));
    chk("n3.chg_oob", 128'(t_chg_valid), 128'(0));
    chk("n3.q_oob", 128'(t_q), 128'(0));
    @(negedge clk);
    chk("n3.err_clear", 128'(t_err), 128'(0));
    t_write(2'd2, M_D, 8'h5A);
    chk("n3.err_ok", 128'(t_err), 128'(0));
    chk("n3.chg_ok", 128'(t_chg_valid), 128'(1));
    chk("n3.q_ok", 128'(t_q), 128'(24'h5A_0000));
    t_write(2'd3, M_T, 8'hFF);
    chk("n3.err_oob2", 128'(t_err), 128'(1));
    chk("n3.q_oob2", 128'(t_q), 128'(24'h5A_0000));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
